vector_exec_unit: RTL and testbench

- Vector execute stage directly downstream of the 32x128 vector register file.
- Consumes the file's two 128-bit read operands plus an opcode and destination address, and computes a lane-wise result.
- Drives the register file's write port (write_enable / write_addr / write_data) as the writeback path.
- Single-cycle logic/add ops run back-to-back; lane-wise multiply is sequential, one lane per cycle, with input backpressure.

---
 rtl/vector_pkg.sv | 12 +
 rtl/vector_lane_alu.sv | 20 ++
 rtl/vector_exec_unit.sv | 112 +++++++++++
 tb/tb_vector_exec_unit.sv | 128 ++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// vector_pkg: shared types, widths and lane helper for the vector register file datapath
package vector_pkg;
  localparam int LANES = 4;
  localparam int ELEM_WIDTH = 32;
  localparam int VREG_ADDR_W = 5;
  localparam int VREG_WIDTH = 128;
  typedef enum logic [2:0] {VADD, VSUB, VAND, VOR, VXOR, VMUL, VSLL, VRSV} vop_e;
  typedef enum logic {IDLE, MUL} vstate_e;
  function automatic logic [ELEM_WIDTH-1:0] lane_slice(input logic [VREG_WIDTH-1:0] v, input int i);
    return v[i*ELEM_WIDTH +: ELEM_WIDTH];
  endfunction
endpackage

// File: rtl/vector_lane_alu.sv
// vector_lane_alu: combinational single-lane ALU
module vector_lane_alu
  import vector_pkg::*;
#(
  parameter int EW = 32
) (
  input  logic [EW-1:0] a_i,
  input  logic [EW-1:0] b_i,
  input  vop_e          op_i,
  output logic [EW-1:0] res_o
);
  localparam int SW = $clog2(EW);
  assign res_o = op_i == VADD ? a_i + b_i :
                 op_i == VSUB ? a_i - b_i :
                 op_i == VAND ? a_i & b_i :
                 op_i == VOR  ? a_i | b_i :
                 op_i == VXOR ? a_i ^ b_i :
                 op_i == VMUL ? a_i * b_i :
                 op_i == VSLL ? a_i << b_i[SW-1:0] : '0;
endmodule

// File: rtl/vector_exec_unit.sv
// vector_exec_unit: lane-wise execute stage feeding the vector register file write port
module vector_exec_unit
  import vector_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             opcode,
  input  logic [VREG_WIDTH-1:0]  operand_1,
  input  logic [VREG_WIDTH-1:0]  operand_2,
  input  logic [VREG_ADDR_W-1:0] dest_addr,
  output logic                   write_enable,
  output logic [VREG_ADDR_W-1:0] write_addr,
  output logic [VREG_WIDTH-1:0]  write_data,
  output logic                   busy,
  output logic                   illegal_op
);
  localparam int LW = $clog2(LANES);
  vstate_e state_q, state_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [VREG_WIDTH-1:0] op1_q, op1_d, op2_q, op2_d, acc_q, acc_d, wdata_q, wdata_d, single_res;
  logic [VREG_ADDR_W-1:0] dest_q, dest_d, waddr_q, waddr_d;
  logic we_q, we_d, ill_q, ill_d, accept;
  logic [ELEM_WIDTH-1:0] mul_res;
  vop_e op;
  assign op = vop_e'(opcode);
  assign in_ready = state_q == IDLE;
  assign busy = state_q == MUL;
  assign accept = in_valid && in_ready;
  assign write_enable = we_q;
  assign write_addr = waddr_q;
  assign write_data = wdata_q;
  assign illegal_op = ill_q;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    vector_lane_alu #(.EW(ELEM_WIDTH)) u_alu (
      .a_i(lane_slice(operand_1, i)),
      .b_i(lane_slice(operand_2, i)),
      .op_i(op),
      .res_o(single_res[i*ELEM_WIDTH +: ELEM_WIDTH])
    );
  end
  // one shared ALU walks the latched operands a lane per cycle for VMUL
  vector_lane_alu #(.EW(ELEM_WIDTH)) u_mul (
    .a_i(lane_slice(op1_q, int'(lane_q))),
    .b_i(lane_slice(op2_q, int'(lane_q))),
    .op_i(VMUL),
    .res_o(mul_res)
  );
  always_comb begin
    state_d = state_q;
    lane_d = lane_q;
    op1_d = op1_q;
    op2_d = op2_q;
    dest_d = dest_q;
    acc_d = acc_q;
    we_d = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    ill_d = 1'b0;
    if (accept) begin
      if (op == VMUL) begin
        state_d = MUL;
        lane_d = '0;
        op1_d = operand_1;
        op2_d = operand_2;
        dest_d = dest_addr;
      end else if (op == VRSV) begin
        ill_d = 1'b1;
      end else begin
        we_d = 1'b1;
        waddr_d = dest_addr;
        wdata_d = single_res;
      end
    end
    if (state_q == MUL) begin
      acc_d[lane_q*ELEM_WIDTH +: ELEM_WIDTH] = mul_res;
      lane_d = lane_q + LW'(1);
      if (lane_q == LW'(LANES-1)) begin
        state_d = IDLE;
        we_d = 1'b1;
        waddr_d = dest_q;
        wdata_d = acc_d;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      lane_q <= '0;
      op1_q <= '0;
      op2_q <= '0;
      dest_q <= '0;
      acc_q <= '0;
      we_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      ill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q <= lane_d;
      op1_q <= op1_d;
      op2_q <= op2_d;
      dest_q <= dest_d;
      acc_q <= acc_d;
      we_q <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      ill_q <= ill_d;
    end
  end
endmodule

// File: tb/tb_vector_exec_unit.sv
// tb_vector_exec_unit: directed stimulus with a writeback scoreboard checked by a monitor
module tb_vector_exec_unit;
  logic clock = 1'b0, reset = 1'b1, in_valid = 1'b0, in_ready;
  logic [2:0] opcode = '0;
  logic [127:0] operand_1 = '0, operand_2 = '0;
  logic [4:0] dest_addr = '0;
  logic write_enable, busy, illegal_op;
  logic [4:0] write_addr;
  logic [127:0] write_data;
  typedef struct {logic [4:0] a; logic [127:0] d;} wb_t;
  wb_t exp_q[$];
  int passed = 0, total = 0, ill_seen = 0, cnt;

  vector_exec_unit dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .operand_1(operand_1), .operand_2(operand_2), .dest_addr(dest_addr),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .busy(busy), .illegal_op(illegal_op)
  );

  always #5 clock = ~clock;

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  task automatic expect_wb(input logic [4:0] a, input logic [127:0] d);
    wb_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [2:0] op, input logic [127:0] a, input logic [127:0] b, input logic [4:0] d);
    opcode = op;
    operand_1 = a;
    operand_2 = b;
    dest_addr = d;
    in_valid = 1'b1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [127:0] a, input logic [127:0] b, input logic [4:0] d);
    drive(op, a, b, d);
    tick(1);
    in_valid = 1'b0;
  endtask

  always @(negedge clock) begin
    if (illegal_op) ill_seen++;
    if (write_enable) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wb", {123'd0, write_addr}, 128'hx);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        chk("wb_addr", {123'd0, write_addr}, {123'd0, e.a});
        chk("wb_data", write_data, e.d);
      end
    end
  end

  initial begin
    tick(2);
    chk("rst_we", {127'd0, write_enable}, 128'd0);
    chk("rst_addr", {123'd0, write_addr}, 128'd0);
    chk("rst_data", write_data, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_ill", {127'd0, illegal_op}, 128'd0);
    chk("rst_ready", {127'd0, in_ready}, 128'd1);
    reset = 1'b0;
    tick(1);
    expect_wb(5'd3, 128'd0);
    issue(3'b000, {4{32'hFFFFFFFF}}, {4{32'h1}}, 5'd3);
    tick(2);
    expect_wb(5'd2, {16{8'h5A}});
    expect_wb(5'd4, {4{32'hFFFFFFFE}});
    drive(3'b100, {16{8'hA5}}, {16{8'hFF}}, 5'd2);
    tick(1);
    issue(3'b001, {4{32'd5}}, {4{32'd7}}, 5'd4);
    chk("b2b_we2", {127'd0, write_enable}, 128'd1);
    tick(2);
    expect_wb(5'd5, {32'hFFFFFFFE, 32'd42, 32'h0, 32'd12});
    expect_wb(5'd6, {4{32'd3}});
    drive(3'b101, {32'hFFFFFFFF, 32'd7, 32'h10000, 32'd3}, {32'd2, 32'd6, 32'h10000, 32'd4}, 5'd5);
    tick(1);
    drive(3'b000, {4{32'd1}}, {4{32'd2}}, 5'd6);
    chk("mul_busy", {127'd0, busy}, 128'd1);
    cnt = 0;
    while (!in_ready && cnt < 10) begin
      cnt++;
      tick(1);
    end
    chk("mul_stall", 128'(cnt), 128'd4);
    chk("mul_wb_we", {127'd0, write_enable}, 128'd1);
    tick(1);
    in_valid = 1'b0;
    tick(3);
    issue(3'b101, {4{32'd9}}, {4{32'd9}}, 5'd7);
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("abort_busy", {127'd0, busy}, 128'd0);
    chk("abort_ready", {127'd0, in_ready}, 128'd1);
    chk("abort_we", {127'd0, write_enable}, 128'd0);
    tick(6);
    issue(3'b111, {4{32'd1}}, {4{32'd1}}, 5'd8);
    chk("ill_pulse", {127'd0, illegal_op}, 128'd1);
    chk("ill_we", {127'd0, write_enable}, 128'd0);
    tick(1);
    chk("ill_drop", {127'd0, illegal_op}, 128'd0);
    tick(1);
    expect_wb(5'd9, {32'd2, 32'd1, 32'h80000000, 32'd1});
    issue(3'b110, {4{32'd1}}, {32'd33, 32'd32, 32'd31, 32'd0}, 5'd9);
    tick(4);
    chk("sb_drained", 128'(exp_q.size()), 128'd0);
    chk("ill_count", 128'(ill_seen), 128'd1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
